reg_bridge: RTL and testbench
=============================

REG_BRIDGE -- requirements
Module: reg_bridge

Interface
REQ-001 Parameter DWIDTH, default 8, register data width in bits.
REQ-002 Parameter AWIDTH, default 8, register address width in bits.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  bridge accepts request this cycle.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  AWIDTH  target register address.
REQ-009 req_wdata  input  DWIDTH  write data; ignored for reads.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  consumer accepts response.
REQ-012 rsp_write  output  1  echo of req_write for this response.
REQ-013 rsp_rdata  output  DWIDTH  read data; 0 for write responses.
REQ-014 reg_op  output  2  register-port opcode: NOP=2'b00, RD=2'b01, WR=2'b10.
REQ-015 reg_addr  output  AWIDTH  register-port address.
REQ-016 reg_wdata  output  DWIDTH  register-port write data.
REQ-017 reg_rdata  input  DWIDTH  register-port read data; registered by the register block, valid the cycle after RD is presented.
REQ-018 rd_cnt  output  16  completed-read count.
REQ-019 wr_cnt  output  16  completed-write count.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_RD, and RESP; all outputs SHALL be registered or decoded from state/registers only, with no combinational path from req_* or reg_rdata to any output.
REQ-021 IDLE: req_ready=1; on req_valid&&req_ready, capture write/addr/wdata and go to ISSUE.
REQ-022 ISSUE (exactly 1 cycle): reg_op=WR or RD, reg_addr/reg_wdata = captured values (reg_wdata=0 for RD); next state is RESP for a write and WAIT_RD for a read.
REQ-023 WAIT_RD (exactly 1 cycle): capture reg_rdata into rsp_rdata; next state RESP.
REQ-024 RESP: rsp_valid=1, with rsp_write/rsp_rdata stable until rsp_ready; on rsp_valid&&rsp_ready, go to IDLE.
REQ-025 Outside ISSUE: reg_op=NOP, reg_addr=0, reg_wdata=0.
REQ-026 req_ready SHALL be 0 in every state except IDLE; at most one transaction SHALL be outstanding.
REQ-027 Latency from acceptance cycle N: reg_op asserted in N+1; write rsp_valid in N+2; read rsp_valid in N+3.
REQ-028 Minimum back-to-back throughput: one write per 3 cycles; one read per 4 cycles (rsp_ready held high).
REQ-029 rd_cnt/wr_cnt SHALL increment by 1 on the response handshake of a read/write respectively, wrapping 16'hFFFF->0.
REQ-030 rsp_ready held low SHALL stall in RESP indefinitely, with no reg_op activity and no counter change.
REQ-031 req_valid asserted outside IDLE SHALL be ignored (not captured) until IDLE.
REQ-032 Address and data SHALL pass through unmodified, with no range check; addresses unmapped in the register block still complete normally.

Reset
REQ-033 rst SHALL take priority over all other events in the same cycle.
REQ-034 After the reset cycle: state=IDLE, req_ready=1, rsp_valid=0, rsp_write=0, rsp_rdata=0, reg_op=NOP, reg_addr=0, reg_wdata=0, rd_cnt=0, wr_cnt=0.
REQ-035 Reset in any non-IDLE state SHALL abandon the in-flight transaction with no response and no counter update; reg_op SHALL be NOP in the cycle after reset.

Verification
REQ-036 Write 0x00<-0xA5, then read 0x00 -> reg_op WR at N+1 with addr 0x00/wdata 0xA5, write response at N+2, read rsp_rdata=0xA5 at N+3 after acceptance, wr_cnt=1, rd_cnt=1.
REQ-037 Writes 0x01<-0x3C and 0x00<-0xC3, then reads of 0x01 and 0x00 -> 0x3C, 0xC3; reg_op is NOP in all cycles outside ISSUE.
REQ-038 rsp_ready low for 10 cycles during a read response -> rsp_valid/rsp_rdata held stable, req_ready=0, reg_op=NOP, rd_cnt unchanged until the handshake.
REQ-039 rst asserted while in ISSUE of a write -> no response; next cycle reg_op=NOP, req_ready=1, wr_cnt=0.
REQ-040 Preload wr_cnt to 16'hFFFF via 65535 writes, then one more write -> wr_cnt=0.
REQ-041 req_valid held high with changing payload during a busy read -> only the payload present at the IDLE acceptance cycle is issued.

Source files
------------

// File: rtl/reg_bridge.sv
`timescale 1ns/1ps
// reg_bridge: single-outstanding request/response bridge onto a simple
// register port (NOP/RD/WR opcode, one-cycle registered read data).
// Every output comes from a flop or is decoded from the state register,
// so no input ever reaches an output combinationally.
module reg_bridge #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic [1:0]        reg_op,
   output logic [AWIDTH-1:0] reg_addr,
   output logic [DWIDTH-1:0] reg_wdata,
   input  logic [DWIDTH-1:0] reg_rdata,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
);

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2,
      RESP    = 2'd3
   } state_t;

   state_t              state_p0;
   state_t              state_nxt;
   logic                write_p0;
   logic [AWIDTH-1:0]   addr_p0;
   logic [DWIDTH-1:0]   wdata_p0;
   logic [DWIDTH-1:0]   rdata_p1;
   logic                req_hs;
   logic                rsp_hs;
   logic [15:0]         rd_cnt_nxt;
   logic [15:0]         wr_cnt_nxt;

   // Transaction counters wrap naturally at 16 bits.
   function automatic logic [15:0] cnt_inc(input logic [15:0] c);
      return c + 16'd1;
   endfunction

   assign req_hs    = (state_p0 == IDLE) && req_valid;
   assign rsp_hs    = (state_p0 == RESP) && rsp_ready;
   assign rsp_write = write_p0;
   assign rsp_rdata = rdata_p1;

   // State register; reset abandons any in-flight transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_p0 <= IDLE;
      end else begin
         state_p0 <= state_nxt;
      end
   end

   // Next-state: ISSUE and WAIT_RD each last exactly one cycle.
   always_comb begin
      state_nxt = state_p0;
      unique case (state_p0)
         IDLE:    if (req_valid) state_nxt = ISSUE;
         ISSUE:   state_nxt = write_p0 ? RESP : WAIT_RD;
         WAIT_RD: state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode from state and captured request only.
   always_comb begin
      req_ready = (state_p0 == IDLE);
      rsp_valid = (state_p0 == RESP);
      reg_op    = OP_NOP;
      reg_addr  = '0;
      reg_wdata = '0;
      if (state_p0 == ISSUE) begin
         reg_op    = write_p0 ? OP_WR : OP_RD;
         reg_addr  = addr_p0;
         reg_wdata = write_p0 ? wdata_p0 : '0;
      end
   end

   // Stage p0: capture request kind on acceptance (reset so rsp_write starts at 0).
   always_ff @(posedge clk) begin
      if (rst) begin
         write_p0 <= 1'b0;
      end else if (req_hs) begin
         write_p0 <= req_write;
      end
   end

   // Stage p0: capture request address/data on acceptance.
   always_ff @(posedge clk) begin
      if (req_hs) begin
         addr_p0  <= req_addr;
         wdata_p0 <= req_wdata;
      end
   end

   // Stage p1: response data, cleared at acceptance so writes answer 0, loaded in WAIT_RD.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_p1 <= '0;
      end else if (req_hs) begin
         rdata_p1 <= '0;
      end else if (state_p0 == WAIT_RD) begin
         rdata_p1 <= reg_rdata;
      end
   end

   // Counter next values: bump only on the response handshake of the matching kind.
   always_comb begin
      rd_cnt_nxt = rd_cnt;
      wr_cnt_nxt = wr_cnt;
      if (rsp_hs) begin
         if (write_p0) wr_cnt_nxt = cnt_inc(wr_cnt);
         else          rd_cnt_nxt = cnt_inc(rd_cnt);
      end
   end

   // Counter registers; reset wins over a same-cycle handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt <= 16'd0;
         wr_cnt <= 16'd0;
      end else begin
         rd_cnt <= rd_cnt_nxt;
         wr_cnt <= wr_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_reg_bridge.sv
`timescale 1ns/1ps
// Directed bench for reg_bridge with a response scoreboard and a small
// register-block model (one-cycle registered read data).
`define CK(tag, o, e) begin checks++; if ((32'(o)) !== (32'(e))) begin errors++; $error("FAIL %s: observed=%0h expected=%0h", tag, 32'(o), 32'(e)); end end
module tb_reg_bridge;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    reg_op;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata = '0;
  logic [15:0]   rd_cnt;
  logic [15:0]   wr_cnt;

  always #5 clk = ~clk;

  reg_bridge #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .reg_op(reg_op), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  // Register block model: read data appears the cycle after RD, 0xEE otherwise.
  logic [DW-1:0] mem [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (reg_op == 2'b10) mem[reg_addr] <= reg_wdata;
    if (reg_op == 2'b01) reg_rdata <= mem[reg_addr];
    else                 reg_rdata <= 8'hEE;
  end

  typedef struct packed {
    logic          w;
    logic [DW-1:0] d;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] shadow [256];
  int            errors = 0;
  int            checks = 0;
  logic [15:0]   exp_rd = 16'd0;
  logic [15:0]   exp_wr = 16'd0;

  // One transaction, entered at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                     input int stall, input bit junk);
    rsp_t e;
    int   lat;
    `CK("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    e.w = w;
    e.d = w ? 8'h00 : shadow[a];
    sb.push_back(e);
    if (w) shadow[a] = d;
    rsp_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    if (junk) begin
      req_write = 1'b1; req_addr = 8'h81; req_wdata = 8'h5A;
    end else begin
      req_valid = 1'b0;
    end
    `CK("issue_op", reg_op, w ? 2 : 1);
    `CK("issue_addr", reg_addr, a);
    `CK("issue_wdata", reg_wdata, w ? d : 8'h00);
    `CK("issue_req_ready", req_ready, 0);
    `CK("issue_rsp_valid", rsp_valid, 0);
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      if (junk) begin req_addr = 8'h81 + 8'(lat); req_wdata = 8'(lat); end
      @(negedge clk);
      lat++;
      if (!rsp_valid) `CK("wait_op_nop", reg_op, 0);
    end
    `CK("rsp_latency", lat, w ? 2 : 3);
    if (sb.size() == 0) begin
      `CK("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int k = 0; k <= stall; k++) begin
      checks++;
      if (rsp_rdata !== e.d) begin
        errors++;
        $error("FAIL rsp_rdata_stable: observed=%0h expected=%0h", rsp_rdata, e.d);
      end
      `CK("rsp_valid", rsp_valid, 1);
      `CK("rsp_write", rsp_write, e.w);
      `CK("rsp_rdata", rsp_rdata, e.d);
      `CK("resp_op_nop", reg_op, 0);
      `CK("resp_req_ready", req_ready, 0);
      `CK("resp_rd_cnt", rd_cnt, exp_rd);
      `CK("resp_wr_cnt", wr_cnt, exp_wr);
      if (k == stall) begin
        rsp_ready = 1'b1;
        req_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    if (w) exp_wr++;
    else   exp_rd++;
    `CK("done_rd_cnt", rd_cnt, exp_rd);
    `CK("done_wr_cnt", wr_cnt, exp_wr);
    `CK("done_rsp_valid", rsp_valid, 0);
    `CK("done_op_nop", reg_op, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    `CK("rst_req_ready", req_ready, 1);
    `CK("rst_rsp_valid", rsp_valid, 0);
    `CK("rst_rsp_write", rsp_write, 0);
    `CK("rst_rsp_rdata", rsp_rdata, 0);
    `CK("rst_reg_op", reg_op, 0);
    `CK("rst_reg_addr", reg_addr, 0);
    `CK("rst_reg_wdata", reg_wdata, 0);
    `CK("rst_rd_cnt", rd_cnt, 0);
    `CK("rst_wr_cnt", wr_cnt, 0);
    rst = 1'b0;

    // Reset during ISSUE of a write abandons it
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h7F; req_wdata = 8'h11;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    `CK("abort_issue_op", reg_op, 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    `CK("abort_op_nop", reg_op, 0);
    `CK("abort_req_ready", req_ready, 1);
    `CK("abort_wr_cnt", wr_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $error("FAIL abort_no_rsp: observed=%0h expected=0", rsp_valid);
      end
      @(negedge clk);
    end

    // Write then read back
    txn(1'b1, 8'h00, 8'hA5, 0, 1'b0);
    txn(1'b0, 8'h00, 8'h00, 0, 1'b0);

    // Two writes, two reads, back to back
    txn(1'b1, 8'h01, 8'h3C, 0, 1'b0);
    txn(1'b1, 8'h00, 8'hC3, 0, 1'b0);
    txn(1'b0, 8'h01, 8'h00, 0, 1'b0);
    txn(1'b0, 8'h00, 8'h00, 0, 1'b0);

    // Read response stalled for 10 cycles
    txn(1'b0, 8'h01, 8'h00, 10, 1'b0);

    // Busy read with req_valid held and payload changing; junk must not land
    txn(1'b0, 8'h00, 8'h00, 0, 1'b1);
    txn(1'b0, 8'h81, 8'h00, 0, 1'b0);
    txn(1'b0, 8'h82, 8'h00, 0, 1'b0);

    // Top-of-map address passes through unchanged
    txn(1'b1, 8'hFF, 8'h96, 0, 1'b0);
    txn(1'b0, 8'hFF, 8'h00, 0, 1'b0);

    // Preload the write counter to its maximum, then wrap
    force dut.wr_cnt_nxt = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.wr_cnt_nxt;
    exp_wr = 16'hFFFF;
    checks++;
    if (wr_cnt !== 16'hFFFF) begin
      errors++;
      $error("FAIL preload_wr_cnt: observed=%0h expected=ffff", wr_cnt);
    end
    txn(1'b1, 8'h10, 8'h42, 0, 1'b0);
    checks++;
    if (wr_cnt !== 16'h0000) begin
      errors++;
      $error("FAIL wrap_wr_cnt: observed=%0h expected=0", wr_cnt);
    end
    txn(1'b0, 8'h10, 8'h00, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
